// File: rtl/u_wb_buf.sv
// u_wb_buf: register-file write-back delay buffer.
// Delays each execute result by DEPTH stages before it is written to the
// register file. Provides stall/flush control, an occupancy count and NRD
// combinational forwarding lookup ports that return the youngest in-flight
// value for a source register.
module u_wb_buf #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NRD   = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       in_we,
  input  logic [AW-1:0]              in_a,
  input  logic [XLEN-1:0]            in_d,
  input  logic [NRD*AW-1:0]          lk_a,
  output logic [NRD-1:0]             lk_hit,
  output logic [NRD*XLEN-1:0]        lk_d,
  output logic                       rf_rd_e,
  output logic [AW-1:0]              rf_rd_a,
  output logic [XLEN-1:0]            rf_rd_i,
  output logic [$clog2(DEPTH+1)-1:0] pend_cnt
);

  localparam int CW = $clog2(DEPTH + 1);

  // One delay stage: write enable, destination register, result.
  typedef struct packed {
    logic            we;
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
  } entry_t;

  entry_t stg [DEPTH];
  entry_t in_ent;

  // Canonicalise the incoming entry: writes to x0 become empty entries,
  // and empty entries carry all-zero address and data.
  always_comb begin
    in_ent    = '0;
    in_ent.we = in_we & (in_a != '0);
    if (in_ent.we) begin
      in_ent.a = in_a;
      in_ent.d = in_d;
    end
  end

  // Stage pipeline: flush clears, stall holds, otherwise shift by one.
  // NOTE: every stage is reset (not just the valid bits) because the
  // register-file outputs expose address and data, which must read 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
    end else if (!stall) begin
      // NOTE: non-blocking assignments let every stage sample the old value
      // of its neighbour, so the loop order does not matter.
      stg[0] <= in_ent;
      for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
    end
  end

  // Register-file port: the write is suppressed while stalled so each entry
  // commits exactly once, on its first un-stalled edge in the last stage.
  assign rf_rd_e = stg[DEPTH-1].we & ~stall;
  assign rf_rd_a = stg[DEPTH-1].a;
  assign rf_rd_i = stg[DEPTH-1].d;

  // Forwarding lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    // NOTE: defaults before the loops keep this block free of latches.
    lk_hit = '0;
    lk_d   = '0;
    for (int i = 0; i < NRD; i++) begin
      if (lk_a[i*AW +: AW] != '0) begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (stg[k].we && (stg[k].a == lk_a[i*AW +: AW])) begin
            lk_hit[i]            = 1'b1;
            lk_d[i*XLEN +: XLEN] = stg[k].d;
          end
        end
      end
    end
  end

  // Occupancy: number of stages holding a valid write.
  always_comb begin
    pend_cnt = '0;
    for (int k = 0; k < DEPTH; k++) pend_cnt = pend_cnt + CW'(stg[k].we);
  end

endmodule

// File: tb/tb_u_wb_buf.sv
// tb_u_wb_buf: self-checking bench for u_wb_buf (DEPTH=3, NRD=2).
// Expected commits are queued when an entry is accepted and compared in
// order as the DUT presents them on the register-file port.
module tb_u_wb_buf;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int NRD   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 stall, flush, in_we;
  logic [AW-1:0]        in_a;
  logic [XLEN-1:0]      in_d;
  logic [NRD*AW-1:0]    lk_a;
  logic [NRD-1:0]       lk_hit;
  logic [NRD*XLEN-1:0]  lk_d;
  logic                 rf_rd_e;
  logic [AW-1:0]        rf_rd_a;
  logic [XLEN-1:0]      rf_rd_i;
  logic [CW-1:0]        pend_cnt;

  typedef struct {
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  u_wb_buf #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .NRD(NRD)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .stall    (stall),
    .flush    (flush),
    .in_we    (in_we),
    .in_a     (in_a),
    .in_d     (in_d),
    .lk_a     (lk_a),
    .lk_hit   (lk_hit),
    .lk_d     (lk_d),
    .rf_rd_e  (rf_rd_e),
    .rf_rd_a  (rf_rd_a),
    .rf_rd_i  (rf_rd_i),
    .pend_cnt (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    in_we = we;
    in_a  = a;
    in_d  = d;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0);
  endtask

  // Scoreboard: at mid-cycle the inputs are stable for the coming edge.
  // Pop a commit if one is presented, then record what the edge will accept.
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
    end else begin
      if (rf_rd_e) begin
        if (sb.size() == 0) begin
          check("sb_spurious_we", rf_rd_e, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_commit_a", rf_rd_a, e.a);
          check("sb_commit_d", rf_rd_i, e.d);
        end
      end
      if (flush) sb.delete();
      else if (!stall && in_we && in_a != '0) sb.push_back('{a: in_a, d: in_d});
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rstn  = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    lk_a  = {5'd5, 5'd5};
    idle();

    // Reset state
    #1;
    check("rst_rf_e", rf_rd_e, 1'b0);
    check("rst_rf_a", rf_rd_a, '0);
    check("rst_rf_d", rf_rd_i, '0);
    check("rst_pend", pend_cnt, '0);
    check("rst_hit", lk_hit, '0);
    check("rst_lkd", lk_d, '0);
    @(negedge clk);
    #1 rstn = 1'b1;
    tick();

    // 1. Single write, latency and forwarding window
    drive(1'b1, 5'd5, 32'h1234);
    tick();
    idle();
    check("t1_e1_rf_e", rf_rd_e, 1'b0);
    check("t1_e1_pend", pend_cnt, 1);
    check("t1_e1_hit", lk_hit, 2'b11);
    check("t1_e1_lkd", lk_d, {32'h1234, 32'h1234});
    tick();
    check("t1_e2_rf_e", rf_rd_e, 1'b0);
    check("t1_e2_pend", pend_cnt, 1);
    tick();
    check("t1_e3_rf_e", rf_rd_e, 1'b1);
    check("t1_e3_rf_a", rf_rd_a, 5'd5);
    check("t1_e3_rf_d", rf_rd_i, 32'h1234);
    check("t1_e3_pend", pend_cnt, 1);
    check("t1_e3_hit", lk_hit, 2'b11);
    tick();
    check("t1_e4_rf_e", rf_rd_e, 1'b0);
    check("t1_e4_pend", pend_cnt, 0);
    check("t1_e4_hit", lk_hit, 2'b00);

    // 2. x0 suppression
    drive(1'b1, 5'd0, 32'hFFFF);
    lk_a = '0;
    tick();
    idle();
    for (int c = 0; c < DEPTH + 1; c++) begin
      check("t2_rf_e", rf_rd_e, 1'b0);
      check("t2_pend", pend_cnt, 0);
      check("t2_hit", lk_hit, 2'b00);
      check("t2_lkd", lk_d, '0);
      tick();
    end

    // 3. Youngest-wins forwarding
    drive(1'b1, 5'd7, 32'hA);
    tick();
    drive(1'b1, 5'd7, 32'hB);
    tick();
    idle();
    lk_a = {5'd7, 5'd7};
    #1;
    check("t3_hit", lk_hit, 2'b11);
    check("t3_lkd", lk_d, {32'hB, 32'hB});
    check("t3_pend", pend_cnt, 2);
    lk_a = {5'd8, 5'd8};
    #1;
    check("t3_miss_hit", lk_hit, 2'b00);
    check("t3_miss_lkd", lk_d, '0);
    lk_a = {5'd8, 5'd7};
    #1;
    check("t3_mixed_hit", lk_hit, 2'b01);
    check("t3_mixed_lkd", lk_d, {32'h0, 32'hB});
    for (int c = 0; c < DEPTH; c++) tick();
    check("t3_drain_pend", pend_cnt, 0);

    // 4. Stall holds the last stage and drops new input
    drive(1'b1, 5'd3, 32'h55);
    tick();
    idle();
    tick();
    tick();
    check("t4_pre_rf_e", rf_rd_e, 1'b1);
    stall = 1'b1;
    drive(1'b1, 5'd9, 32'h99);
    #1;
    for (int c = 0; c < 2; c++) begin
      check("t4_st_rf_e", rf_rd_e, 1'b0);
      check("t4_st_rf_a", rf_rd_a, 5'd3);
      check("t4_st_rf_d", rf_rd_i, 32'h55);
      check("t4_st_pend", pend_cnt, 1);
      tick();
    end
    stall = 1'b0;
    idle();
    #1;
    check("t4_rel_rf_e", rf_rd_e, 1'b1);
    check("t4_rel_rf_a", rf_rd_a, 5'd3);
    tick();
    for (int c = 0; c < DEPTH; c++) begin
      check("t4_post_rf_e", rf_rd_e, 1'b0);
      check("t4_post_pend", pend_cnt, 0);
      tick();
    end

    // 5. Flush with stall and a valid input
    drive(1'b1, 5'd1, 32'h11);
    tick();
    drive(1'b1, 5'd2, 32'h22);
    tick();
    drive(1'b1, 5'd3, 32'h33);
    tick();
    check("t5_pre_pend", pend_cnt, 3);
    flush = 1'b1;
    stall = 1'b1;
    drive(1'b1, 5'd4, 32'h44);
    tick();
    flush = 1'b0;
    stall = 1'b0;
    idle();
    lk_a = {5'd3, 5'd1};
    #1;
    check("t5_pend", pend_cnt, 0);
    check("t5_hit", lk_hit, 2'b00);
    lk_a = {5'd4, 5'd2};
    #1;
    check("t5_hit_new", lk_hit, 2'b00);
    for (int c = 0; c < DEPTH; c++) begin
      check("t5_rf_e", rf_rd_e, 1'b0);
      tick();
    end

    // 6. Async reset mid-stream
    drive(1'b1, 5'd10, 32'hAA);
    tick();
    drive(1'b1, 5'd11, 32'hBB);
    tick();
    drive(1'b1, 5'd12, 32'hCC);
    tick();
    idle();
    lk_a = {5'd12, 5'd10};
    check("t6_pre_rf_e", rf_rd_e, 1'b1);
    check("t6_pre_pend", pend_cnt, 3);
    #2 rstn = 1'b0;
    #1;
    check("t6_rf_e", rf_rd_e, 1'b0);
    check("t6_rf_a", rf_rd_a, '0);
    check("t6_rf_d", rf_rd_i, '0);
    check("t6_pend", pend_cnt, '0);
    check("t6_hit", lk_hit, '0);
    check("t6_lkd", lk_d, '0);
    @(negedge clk);
    #1 rstn = 1'b1;
    for (int c = 0; c < DEPTH + 1; c++) begin
      tick();
      check("t6_post_rf_e", rf_rd_e, 1'b0);
      check("t6_post_pend", pend_cnt, 0);
    end
    drive(1'b1, 5'd6, 32'h66);
    tick();
    idle();
    for (int c = 0; c < DEPTH; c++) tick();
    check("t6_new_pend", pend_cnt, 0);

    // Every accepted entry must have been committed.
    @(negedge clk);
    #1;
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
